iterative_alu: RTL

//  Parametrised multi-cycle ALU. A WIDTH-bit operation is computed by a chain of 4-bit slices,

---
 rtl/iterative_alu_if.sv | 29 ++
 rtl/iterative_alu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/iterative_alu_if.sv
// Request/response bundle for the iterative slice ALU.
// The master issues operations and drains results; the ALU is the slave.
interface iterative_alu_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             pin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             pout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, s, m, pin, out_ready,
    input  in_ready, out_valid, r, pout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, s, m, pin, out_ready,
    output in_ready, out_valid, r, pout, zero, ovf
  );
endinterface

// File: rtl/iterative_alu.sv
// Multi-cycle ALU built from chained 4-bit slices, SLICES_PER_CYCLE per clock,
// with the inter-group carry held in a register between cycles.
module iterative_alu #(
  parameter int WIDTH            = 16,
  parameter int SLICES_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  iterative_alu_if.slave bus
);
  localparam int GW = 4 * SLICES_PER_CYCLE;
  localparam int N  = WIDTH / GW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSK =
    {WIDTH{1'b1}} >> (WIDTH - GW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             c_q, c_d;
  logic             pout_q, pout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [IW-1:0]    idx_q, idx_d;

  // Arithmetic result is x + y + carry; logic result is ~(x ^ y).
  logic [WIDTH-1:0] x_w, y_w;
  assign x_w = a_q
             | (b_q & {WIDTH{s_q[0]}})
             | (~b_q & {WIDTH{s_q[1]}});
  assign y_w = (a_q & ~b_q & {WIDTH{s_q[2]}})
             | (a_q & b_q & {WIDTH{s_q[3]}});

  logic [GW-1:0]    xg, yg, fg;
  logic             cr, gc, gcm;
  int               sh;
  logic [WIDTH-1:0] r_ins;

  always_comb begin
    sh  = GW * int'(idx_q);
    xg  = GW'(x_w >> sh);
    yg  = GW'(y_w >> sh);
    fg  = '0;
    cr  = c_q;
    gcm = 1'b0;
    for (int i = 0; i < GW; i++) begin
      gcm   = cr;
      fg[i] = m_q ? ~(xg[i] ^ yg[i])
                  : (xg[i] ^ yg[i] ^ cr);
      cr    = (xg[i] & yg[i])
            | (cr & (xg[i] | yg[i]));
    end
    gc    = cr;
    r_ins = (r_q & ~(MSK << sh))
          | (WIDTH'(fg) << sh);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    c_d     = c_q;
    r_d     = r_q;
    idx_d   = idx_q;
    pout_d  = pout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          s_d     = bus.s;
          m_d     = bus.m;
          c_d     = bus.pin;
          idx_d   = '0;
        end
      end
      RUN: begin
        r_d   = r_ins;
        c_d   = gc;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(N - 1)) begin
          state_d = DONE;
          pout_d  = gc & ~m_q;
          ovf_d   = (gc ^ gcm) & ~m_q;
          zero_d  = (r_ins == '0);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      c_q     <= 1'b0;
      r_q     <= '0;
      idx_q   <= '0;
      pout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      c_q     <= c_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      pout_q  <= pout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.r         = r_q;
  assign bus.pout      = pout_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
endmodule
